// File: rtl/luma_frame_stats.sv
// luma_frame_stats
// Passes a YUV pixel stream through with one register stage and gathers
// per-frame luma statistics (min, max, sum, pixel count). At frame end the
// accumulators are snapshotted and a serial restoring divider computes the
// mean luma, one quotient bit per cycle, MSB first.
//
// Ports:
//   pixclk, reset              clock, synchronous active-high reset
//   enable                     gate for statistics events (not passthrough)
//   dvi/dtypei/y/u/v/meta_datai -> dvo/dtypeo/yo/uo/vo/meta_datao (1 cycle)
//   y_min/y_max/y_sum/pix_count/y_mean   last completed frame results
//   stats_valid                one-cycle pulse when results update
//   stats_busy                 divider running
//   frame_overrun              one-cycle pulse when a frame end is dropped
//
// Divider FSM
//   state  | meaning
//   S_IDLE | waiting for a frame end
//   S_DIV  | shifting quotient bits; at terminal count load results

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd0
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif

module luma_frame_stats #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                               pixclk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               dvi,
    input  logic [`DTYPE_WIDTH-1:0]            dtypei,
    input  logic [PIXEL_WIDTH-1:0]             y,
    input  logic [PIXEL_WIDTH-1:0]             u,
    input  logic [PIXEL_WIDTH-1:0]             v,
    input  logic [15:0]                        meta_datai,
    output logic                               dvo,
    output logic [`DTYPE_WIDTH-1:0]            dtypeo,
    output logic [PIXEL_WIDTH-1:0]             yo,
    output logic [PIXEL_WIDTH-1:0]             uo,
    output logic [PIXEL_WIDTH-1:0]             vo,
    output logic [15:0]                        meta_datao,
    output logic [PIXEL_WIDTH-1:0]             y_min,
    output logic [PIXEL_WIDTH-1:0]             y_max,
    output logic [PIXEL_WIDTH+COUNT_WIDTH-1:0] y_sum,
    output logic [COUNT_WIDTH-1:0]             pix_count,
    output logic [PIXEL_WIDTH-1:0]             y_mean,
    output logic                               stats_valid,
    output logic                               stats_busy,
    output logic                               frame_overrun
);
    localparam int SUM_WIDTH = PIXEL_WIDTH + COUNT_WIDTH;
    localparam int BIT_W     = $clog2(SUM_WIDTH + 1);

    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t                   state_q, state_d;
    logic                     dvo_q, dvo_d;
    logic [`DTYPE_WIDTH-1:0]  dtypeo_q, dtypeo_d;
    logic [PIXEL_WIDTH-1:0]   yo_q, yo_d, uo_q, uo_d, vo_q, vo_d;
    logic [15:0]              meta_q, meta_d;

    logic [PIXEL_WIDTH-1:0]   acc_min_q, acc_min_d, acc_max_q, acc_max_d;
    logic [SUM_WIDTH-1:0]     acc_sum_q, acc_sum_d;
    logic [COUNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;

    logic [PIXEL_WIDTH-1:0]   snap_min_q, snap_min_d, snap_max_q, snap_max_d;
    logic [SUM_WIDTH-1:0]     snap_sum_q, snap_sum_d;
    logic [COUNT_WIDTH-1:0]   snap_cnt_q, snap_cnt_d;
    logic [SUM_WIDTH-1:0]     quo_q, quo_d;
    logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;

    logic [PIXEL_WIDTH-1:0]   y_min_q, y_min_d, y_max_q, y_max_d, y_mean_q, y_mean_d;
    logic [SUM_WIDTH-1:0]     y_sum_q, y_sum_d;
    logic [COUNT_WIDTH-1:0]   pix_count_q, pix_count_d;
    logic                     stats_valid_q, stats_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     ev_pix, ev_start, ev_end;
    logic [COUNT_WIDTH:0]     rem_shift, rem_diff;

    assign ev_pix   = dvi && enable && (dtypei == `DTYPE_PIXEL);
    assign ev_start = dvi && enable && (dtypei == `DTYPE_FRAME_START);
    assign ev_end   = dvi && enable && (dtypei == `DTYPE_FRAME_END);

    // Restoring step: the sign bit of the trial subtraction is the borrow.
    // The partial remainder is always below the divisor, so the shifted
    // value stays below 2*divisor and the sign bit is reliable.
    assign rem_shift = {rem_q, quo_q[SUM_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, snap_cnt_q};

    always_comb begin
        state_d       = state_q;
        dvo_d         = dvi;
        dtypeo_d      = dtypei;
        yo_d          = y;
        uo_d          = u;
        vo_d          = v;
        meta_d        = meta_datai;
        acc_min_d     = acc_min_q;
        acc_max_d     = acc_max_q;
        acc_sum_d     = acc_sum_q;
        acc_cnt_d     = acc_cnt_q;
        snap_min_d    = snap_min_q;
        snap_max_d    = snap_max_q;
        snap_sum_d    = snap_sum_q;
        snap_cnt_d    = snap_cnt_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        bit_cnt_d     = bit_cnt_q;
        y_min_d       = y_min_q;
        y_max_d       = y_max_q;
        y_sum_d       = y_sum_q;
        pix_count_d   = pix_count_q;
        y_mean_d      = y_mean_q;
        stats_valid_d = 1'b0;
        overrun_d     = 1'b0;

        if (ev_start) begin
            acc_min_d = '1;
            acc_max_d = '0;
            acc_sum_d = '0;
            acc_cnt_d = '0;
        end else if (ev_pix) begin
            if (y < acc_min_q) acc_min_d = y;
            if (y > acc_max_q) acc_max_d = y;
            // Saturated count freezes the sum too, so sum/count stays a sane mean.
            if (acc_cnt_q != '1) begin
                acc_sum_d = acc_sum_q + {{COUNT_WIDTH{1'b0}}, y};
                acc_cnt_d = acc_cnt_q + COUNT_WIDTH'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ev_end) begin
                    snap_min_d = acc_min_q;
                    snap_max_d = acc_max_q;
                    snap_sum_d = acc_sum_q;
                    snap_cnt_d = acc_cnt_q;
                    quo_d      = acc_sum_q;
                    rem_d      = '0;
                    // Empty frame: terminal count immediately, results forced to 0.
                    bit_cnt_d  = (acc_cnt_q == '0) ? '0 : BIT_W'(SUM_WIDTH);
                    state_d    = S_DIV;
                end
            end
            S_DIV: begin
                if (ev_end) overrun_d = 1'b1;
                if (bit_cnt_q != '0) begin
                    rem_d     = rem_diff[COUNT_WIDTH] ? rem_shift[COUNT_WIDTH-1:0]
                                                      : rem_diff[COUNT_WIDTH-1:0];
                    quo_d     = {quo_q[SUM_WIDTH-2:0], ~rem_diff[COUNT_WIDTH]};
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end else begin
                    if (snap_cnt_q == '0) begin
                        y_min_d     = '0;
                        y_max_d     = '0;
                        y_sum_d     = '0;
                        pix_count_d = '0;
                        y_mean_d    = '0;
                    end else begin
                        y_min_d     = snap_min_q;
                        y_max_d     = snap_max_q;
                        y_sum_d     = snap_sum_q;
                        pix_count_d = snap_cnt_q;
                        y_mean_d    = quo_q[PIXEL_WIDTH-1:0];
                    end
                    stats_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            dvo_q         <= 1'b0;
            dtypeo_q      <= '0;
            yo_q          <= '0;
            uo_q          <= '0;
            vo_q          <= '0;
            meta_q        <= '0;
            acc_min_q     <= '0;
            acc_max_q     <= '0;
            acc_sum_q     <= '0;
            acc_cnt_q     <= '0;
            snap_min_q    <= '0;
            snap_max_q    <= '0;
            snap_sum_q    <= '0;
            snap_cnt_q    <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            bit_cnt_q     <= '0;
            y_min_q       <= '0;
            y_max_q       <= '0;
            y_sum_q       <= '0;
            pix_count_q   <= '0;
            y_mean_q      <= '0;
            stats_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dvo_q         <= dvo_d;
            dtypeo_q      <= dtypeo_d;
            yo_q          <= yo_d;
            uo_q          <= uo_d;
            vo_q          <= vo_d;
            meta_q        <= meta_d;
            acc_min_q     <= acc_min_d;
            acc_max_q     <= acc_max_d;
            acc_sum_q     <= acc_sum_d;
            acc_cnt_q     <= acc_cnt_d;
            snap_min_q    <= snap_min_d;
            snap_max_q    <= snap_max_d;
            snap_sum_q    <= snap_sum_d;
            snap_cnt_q    <= snap_cnt_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            bit_cnt_q     <= bit_cnt_d;
            y_min_q       <= y_min_d;
            y_max_q       <= y_max_d;
            y_sum_q       <= y_sum_d;
            pix_count_q   <= pix_count_d;
            y_mean_q      <= y_mean_d;
            stats_valid_q <= stats_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign dvo           = dvo_q;
    assign dtypeo        = dtypeo_q;
    assign yo            = yo_q;
    assign uo            = uo_q;
    assign vo            = vo_q;
    assign meta_datao    = meta_q;
    assign y_min         = y_min_q;
    assign y_max         = y_max_q;
    assign y_sum         = y_sum_q;
    assign pix_count     = pix_count_q;
    assign y_mean        = y_mean_q;
    assign stats_valid   = stats_valid_q;
    assign stats_busy    = (state_q == S_DIV);
    assign frame_overrun = overrun_q;

endmodule
